axis_width_upsizer: RTL and testbench

AXIS_WIDTH_UPSIZER -- requirements
Module: axis_width_upsizer

---
 rtl/axis_width_upsizer.sv | 139 +++++++++++++
 tb/tb_axis_width_upsizer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_width_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow slave beats into one wide master word.
// Two stages: a lane accumulator with a FILL/HOLD FSM, then a registered output slot.
module axis_width_upsizer #(
  parameter int S_TDATA_WIDTH = 64,
  parameter int RATIO         = 8,
  parameter int LANE_ORDER    = 0,
  localparam int M_TDATA_WIDTH = S_TDATA_WIDTH * RATIO,
  localparam int SK            = S_TDATA_WIDTH / 8,
  localparam int MK            = M_TDATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [S_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [SK-1:0]            S_AXIS_TKEEP,
  input  logic                     S_AXIS_TVALID,
  input  logic                     S_AXIS_TLAST,
  output logic                     S_AXIS_TREADY,
  output logic [M_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic [MK-1:0]            M_AXIS_TKEEP,
  output logic                     M_AXIS_TVALID,
  output logic                     M_AXIS_TLAST,
  input  logic                     M_AXIS_TREADY,
  output logic                     partial_word
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]               state;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            lane;
  logic [M_TDATA_WIDTH-1:0] acc_data;
  logic [MK-1:0]            acc_keep;
  logic                     acc_last;
  logic                     acc_partial;

  logic [M_TDATA_WIDTH-1:0] out_data;
  logic [MK-1:0]            out_keep;
  logic                     out_last;
  logic                     out_partial;
  logic                     out_valid;

  logic [M_TDATA_WIDTH-1:0] word_data;
  logic [MK-1:0]            word_keep;
  logic                     s_hs;
  logic                     m_hs;
  logic                     out_free;
  logic                     complete;
  logic                     word_partial;
  logic                     load_direct;
  logic                     load_hold;

  assign s_hs         = S_AXIS_TVALID && (state == FILL);
  assign m_hs         = out_valid && M_AXIS_TREADY;
  assign out_free     = !out_valid || M_AXIS_TREADY;
  assign complete     = s_hs && ((cnt == LAST_LANE) || S_AXIS_TLAST);
  assign word_partial = S_AXIS_TLAST && (cnt != LAST_LANE);
  assign load_direct  = complete && out_free;
  assign load_hold    = (state == HOLD) && out_free;

  // RATIO is a power of two, so RATIO-1-cnt is simply the bitwise inverse of cnt.
  assign lane = (LANE_ORDER == 1) ? ~cnt : cnt;

  // Accumulator contents merged with the beat arriving this cycle; the
  // accumulator is cleared after every word so unfilled lanes stay zero.
  always_comb begin
    word_data = acc_data;
    word_keep = acc_keep;
    word_data[int'(lane)*S_TDATA_WIDTH +: S_TDATA_WIDTH] = S_AXIS_TDATA;
    word_keep[int'(lane)*SK +: SK]                       = S_AXIS_TKEEP;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= FILL;
      cnt         <= '0;
      acc_data    <= '0;
      acc_keep    <= '0;
      acc_last    <= 1'b0;
      acc_partial <= 1'b0;
    end else if (load_direct || load_hold) begin
      state       <= FILL;
      cnt         <= '0;
      acc_data    <= '0;
      acc_keep    <= '0;
      acc_last    <= 1'b0;
      acc_partial <= 1'b0;
    end else if (complete) begin
      state       <= HOLD;
      acc_data    <= word_data;
      acc_keep    <= word_keep;
      acc_last    <= S_AXIS_TLAST;
      acc_partial <= word_partial;
    end else if (s_hs) begin
      cnt      <= cnt + 1'b1;
      acc_data <= word_data;
      acc_keep <= word_keep;
    end
  end

  // Output slot only changes when it is empty or being drained this cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_data    <= '0;
      out_keep    <= '0;
      out_last    <= 1'b0;
      out_partial <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      if (load_direct) begin
        out_data    <= word_data;
        out_keep    <= word_keep;
        out_last    <= S_AXIS_TLAST;
        out_partial <= word_partial;
      end else if (load_hold) begin
        out_data    <= acc_data;
        out_keep    <= acc_keep;
        out_last    <= acc_last;
        out_partial <= acc_partial;
      end
      if (load_direct || load_hold) begin
        out_valid <= 1'b1;
      end else if (m_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign S_AXIS_TREADY = (state == FILL);
  assign M_AXIS_TDATA  = out_data;
  assign M_AXIS_TKEEP  = out_keep;
  assign M_AXIS_TLAST  = out_last;
  assign M_AXIS_TVALID = out_valid;
  assign partial_word  = out_partial;

endmodule

// File: tb/tb_axis_width_upsizer.sv
// Directed bench for axis_width_upsizer (64-bit slave, RATIO 8), with a second
// instance in MSB-first lane order sharing the same stimulus.
module tb_axis_width_upsizer;

  logic         aclk;
  logic         areset;
  logic [63:0]  s_tdata;
  logic [7:0]   s_tkeep;
  logic         s_tvalid;
  logic         s_tlast;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tvalid;
  logic         m_tlast;
  logic         m_tready;
  logic         m_partial;

  logic         s_tready2;
  logic [511:0] m_tdata2;
  logic [63:0]  m_tkeep2;
  logic         m_tvalid2;
  logic         m_tlast2;
  logic         m_partial2;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  typedef struct {
    logic [511:0] d;
    logic [63:0]  k;
    logic         l;
    logic         p;
  } word_t;

  word_t mq[$];

  axis_width_upsizer #(.S_TDATA_WIDTH(64), .RATIO(8), .LANE_ORDER(0)) dut (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready), .partial_word(m_partial)
  );

  axis_width_upsizer #(.S_TDATA_WIDTH(64), .RATIO(8), .LANE_ORDER(1)) dut_msb (
    .aclk(aclk), .areset(areset),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TKEEP(s_tkeep), .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready2),
    .M_AXIS_TDATA(m_tdata2), .M_AXIS_TKEEP(m_tkeep2), .M_AXIS_TVALID(m_tvalid2),
    .M_AXIS_TLAST(m_tlast2), .M_AXIS_TREADY(m_tready), .partial_word(m_partial2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Inputs change just after posedge, so the negedge view predicts the next handshake.
  always @(negedge aclk) begin
    if (m_tvalid && m_tready && !areset) begin
      mq.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast, p: m_partial});
    end
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    logic rdy;
    int   n;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 50) begin
      @(negedge aclk);
      rdy = s_tready;
      if (!rdy) stalls++;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=%0d", 0, 1);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  function automatic logic [511:0] lanes_lsb(input logic [63:0] base);
    logic [511:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[i*64 +: 64] = base + 64'(i);
    return w;
  endfunction

  initial begin
    logic [511:0] e;
    logic [511:0] e2;

    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [511:0] e;
    logic [511:0] e2;

    areset   = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rst_s_tready", 512'(s_tready), 512'(1));
    check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    check("rst_m_tlast", 512'(m_tlast), 512'(0));
    check("rst_partial", 512'(m_partial), 512'(0));
    check("rst_m_tkeep", 512'(m_tkeep), 512'(0));
    check("rst_m_tdata", m_tdata, 512'(0));
    @(posedge aclk);
    #1;

    // Full 8-beat packet, checked the cycle after the last beat.
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(64'(i), 8'hFF, i == 7);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge aclk);
    e = '0;
    e2 = '0;
    for (int i = 0; i < 8; i++) begin
      e[i*64 +: 64]       = 64'(i);
      e2[(7-i)*64 +: 64]  = 64'(i);
    end
    check("full_valid", 512'(m_tvalid), 512'(1));
    check("full_data", m_tdata, e);
    check("full_keep", 512'(m_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    check("full_last", 512'(m_tlast), 512'(1));
    check("full_partial", 512'(m_partial), 512'(0));
    check("msb_full_data", m_tdata2, e2);
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("full_valid_clear", 512'(m_tvalid), 512'(0));
    @(posedge aclk);
    #1;

    // Short packet of three beats.
    send_beat(64'hA, 8'hFF, 1'b0);
    send_beat(64'hB, 8'hFF, 1'b0);
    send_beat(64'hC, 8'hFF, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge aclk);
    e = '0;
    e[63:0]    = 64'hA;
    e[127:64]  = 64'hB;
    e[191:128] = 64'hC;
    e2 = '0;
    e2[511:448] = 64'hA;
    e2[447:384] = 64'hB;
    e2[383:320] = 64'hC;
    check("short_valid", 512'(m_tvalid), 512'(1));
    check("short_data", m_tdata, e);
    check("short_keep", 512'(m_tkeep), 512'(64'h0000_0000_00FF_FFFF));
    check("short_partial", 512'(m_partial), 512'(1));
    check("short_last", 512'(m_tlast), 512'(1));
    check("msb_short_data", m_tdata2, e2);
    check("msb_short_keep", 512'(m_tkeep2), 512'(64'hFFFF_FF00_0000_0000));
    check("msb_short_partial", 512'(m_partial2), 512'(1));
    @(posedge aclk);
    #1;

    // 16 back-to-back beats, one sparse keep, no backpressure.
    mq.delete();
    stalls = 0;
    for (int i = 0; i < 16; i++) send_beat(64'h100 + 64'(i), (i == 3) ? 8'h0F : 8'hFF, i == 15);
    idle(3);
    check("b2b_stalls", 512'(stalls), 512'(0));
    check("b2b_count", 512'(mq.size()), 512'(2));
    if (mq.size() == 2) begin
      check("b2b_w0_data", mq[0].d, lanes_lsb(64'h100));
      check("b2b_w0_keep", 512'(mq[0].k), 512'(64'hFFFF_FFFF_0FFF_FFFF));
      check("b2b_w0_last", 512'(mq[0].l), 512'(0));
      check("b2b_w0_partial", 512'(mq[0].p), 512'(0));
      check("b2b_w1_data", mq[1].d, lanes_lsb(64'h108));
      check("b2b_w1_last", 512'(mq[1].l), 512'(1));
    end

    // Backpressure: first word parks in the output slot, second in HOLD.
    m_tready = 1'b0;
    mq.delete();
    for (int i = 0; i < 16; i++) send_beat(64'h200 + 64'(i), 8'hFF, i == 15);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge aclk);
    check("bp_hold_ready", 512'(s_tready), 512'(0));
    check("bp_valid", 512'(m_tvalid), 512'(1));
    check("bp_data", m_tdata, lanes_lsb(64'h200));
    check("bp_last", 512'(m_tlast), 512'(0));
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("bp_data_stable", m_tdata, lanes_lsb(64'h200));
    check("bp_keep_stable", 512'(m_tkeep), 512'(64'hFFFF_FFFF_FFFF_FFFF));
    check("bp_still_hold", 512'(s_tready), 512'(0));
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    idle(4);
    check("bp_count", 512'(mq.size()), 512'(2));
    if (mq.size() == 2) begin
      check("bp_w0_data", mq[0].d, lanes_lsb(64'h200));
      check("bp_w1_data", mq[1].d, lanes_lsb(64'h208));
      check("bp_w1_last", 512'(mq[1].l), 512'(1));
    end
    @(negedge aclk);
    check("bp_ready_back", 512'(s_tready), 512'(1));
    @(posedge aclk);
    #1;

    // Reset in the middle of a packet drops it; the next packet starts at lane 0.
    mq.delete();
    for (int i = 0; i < 5; i++) send_beat(64'h300 + 64'(i), 8'hFF, 1'b0);
    s_tvalid = 1'b0;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("mid_rst_valid", 512'(m_tvalid), 512'(0));
    check("mid_rst_ready", 512'(s_tready), 512'(1));
    @(posedge aclk);
    #1;
    for (int i = 0; i < 8; i++) send_beat(64'h20 + 64'(i), 8'hFF, i == 7);
    idle(3);
    check("mid_rst_count", 512'(mq.size()), 512'(1));
    if (mq.size() == 1) begin
      check("mid_rst_data", mq[0].d, lanes_lsb(64'h20));
      check("mid_rst_last", 512'(mq[0].l), 512'(1));
      check("mid_rst_partial", 512'(mq[0].p), 512'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
